// File: rtl/pla_res_pkg.sv
// Shared types and sizing for the pipelined PLA restriction evaluator.
// The block's dimensions live here so the top, the projection matrix
// and the testbench all agree on widths.
package pla_res_pkg;

    localparam int N_IN    = 14;  // primary input width
    localparam int N_RES   = 8;   // restricted-space width (rows of lambda)
    localparam int N_TERMS = 16;  // cube slots in the cover
    localparam int N_OUT   = 1;   // output count

    // Address width: wide enough to index the larger of the two tables.
    function automatic int calc_aw(input int n_res, input int n_terms);
        return $clog2((n_res > n_terms) ? n_res : n_terms);
    endfunction

    // Config data width: wide enough for a lambda row or a packed cube.
    function automatic int calc_cw(input int n_in, input int n_res, input int n_out);
        return (n_in > 2 * n_res + n_out) ? n_in : 2 * n_res + n_out;
    endfunction

    localparam int AW = calc_aw(N_RES, N_TERMS);
    localparam int CW = calc_cw(N_IN, N_RES, N_OUT);

    typedef enum logic [1:0] {
        SEL_LAMBDA = 2'd0,
        SEL_CUBE   = 2'd1,
        SEL_POL    = 2'd2,
        SEL_RSVD   = 2'd3
    } cfg_sel_e;

    // One product term: literal mask, literal values, and which outputs it feeds.
    typedef struct packed {
        logic [N_RES-1:0] care;
        logic [N_RES-1:0] val;
        logic [N_OUT-1:0] omask;
    } cube_t;

    localparam int CUBE_W = $bits(cube_t);

endpackage

// File: rtl/gf2_projection.sv
// GF(2) projection z = lambda * x: each output bit is the parity of the
// input bits selected by its lambda row. Purely combinational.
module gf2_projection #(
    parameter int N_IN  = 14,
    parameter int N_RES = 8
) (
    input  logic [N_IN-1:0]             x_i,
    input  logic [N_RES-1:0][N_IN-1:0]  lambda_i,
    output logic [N_RES-1:0]            z_o
);

    // AND-XOR plane: one parity tree per restricted variable.
    always_comb begin
        // NOTE: default every comb output before the loop so no path can infer a latch.
        z_o = '0;
        for (int j = 0; j < N_RES; j++) begin
            z_o[j] = ^(x_i & lambda_i[j]);
        end
    end

endmodule

// File: rtl/pla_res_eval_pipe.sv
// Streaming evaluator for autosymmetric PLA functions f(x) = f_k(lambda(x)).
// Stage 1 projects x through lambda, stage 2 matches the cube cover,
// stage 3 ORs matching cubes per output and applies polarity.
// Configuration is only accepted while the pipe is empty, so stored
// tables never change under in-flight data.
module pla_res_eval_pipe
    import pla_res_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [CW-1:0]    cfg_data,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_y
);

    localparam int AW1 = AW + 1;
    localparam int LW  = (N_RES > 1) ? $clog2(N_RES) : 1;
    localparam int TW  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    // Configuration storage
    logic [N_RES-1:0][N_IN-1:0] lambda_q, lambda_d;
    cube_t [N_TERMS-1:0]        cube_q, cube_d;
    logic [N_OUT-1:0]           pol_q, pol_d;
    logic                       cfg_err_q, cfg_err_d;

    // Pipeline state
    logic                       v1_q, v1_d;
    logic                       v2_q, v2_d;
    logic                       v3_q, v3_d;
    logic [N_RES-1:0]           z1_q, z1_d;
    logic [N_TERMS-1:0]         m2_q, m2_d;
    logic [N_OUT-1:0]           y_q, y_d;

    // Combinational datapath and control
    cfg_sel_e                   sel;
    logic                       addr_ok;
    logic                       cfg_accept;
    logic                       en;
    logic                       accept;
    logic [N_RES-1:0]           z;
    logic [N_TERMS-1:0]         m;
    logic [N_OUT-1:0]           y;

    assign sel        = cfg_sel_e'(cfg_sel);
    assign cfg_ready  = !v1_q && !v2_q && !v3_q;
    assign cfg_accept = cfg_we && cfg_ready && addr_ok;
    assign cfg_err_d  = cfg_we && !cfg_accept;

    // A full output register that is not being drained freezes the whole pipe.
    assign en       = !(v3_q && !out_ready);
    assign in_ready = en && !cfg_we;
    assign accept   = in_valid && in_ready;

    assign out_valid = v3_q;
    assign out_y     = y_q;
    assign cfg_err   = cfg_err_q;

    // Decode whether the write target exists; the reserved select never does.
    always_comb begin
        addr_ok = 1'b0;
        case (sel)
            SEL_LAMBDA: addr_ok = ({1'b0, cfg_addr} < AW1'(N_RES));
            SEL_CUBE:   addr_ok = ({1'b0, cfg_addr} < AW1'(N_TERMS));
            SEL_POL:    addr_ok = 1'b1;
            default:    addr_ok = 1'b0;
        endcase
    end

    // Next state of the configuration tables for an accepted write.
    always_comb begin
        lambda_d = lambda_q;
        cube_d   = cube_q;
        pol_d    = pol_q;
        if (cfg_accept) begin
            case (sel)
                SEL_LAMBDA: lambda_d[cfg_addr[LW-1:0]] = cfg_data[N_IN-1:0];
                SEL_CUBE:   cube_d[cfg_addr[TW-1:0]]   = cube_t'(cfg_data[CUBE_W-1:0]);
                SEL_POL:    pol_d                      = cfg_data[N_OUT-1:0];
                default:    ;
            endcase
        end
    end

    // Stage 1 datapath: project the incoming vector into the restricted space.
    gf2_projection #(
        .N_IN  (N_IN),
        .N_RES (N_RES)
    ) u_proj (
        .x_i      (in_x),
        .lambda_i (lambda_q),
        .z_o      (z)
    );

    // Stage 2 datapath: a cube matches when every cared literal agrees with z.
    always_comb begin
        m = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            m[t] = &(~(z1_q ^ cube_q[t].val) | ~cube_q[t].care);
        end
    end

    // Stage 3 datapath: OR the matching cubes routed to each output, then flip by polarity.
    always_comb begin
        y = '0;
        for (int o = 0; o < N_OUT; o++) begin
            for (int t = 0; t < N_TERMS; t++) begin
                y[o] = y[o] | (m2_q[t] & cube_q[t].omask[o]);
            end
            y[o] = y[o] ^ pol_q[o];
        end
    end

    // Pipeline advance: every stage moves together on en, otherwise holds.
    always_comb begin
        v1_d = en ? accept : v1_q;
        v2_d = en ? v1_q   : v2_q;
        v3_d = en ? v2_q   : v3_q;
        z1_d = (en && accept) ? z : z1_q;
        m2_d = (en && v1_q)   ? m : m2_q;
        y_d  = (en && v2_q)   ? y : y_q;
    end

    // Configuration registers; reset restores identity lambda and an empty cover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the tables are reset on purpose; their power-on contents define the default function.
            for (int j = 0; j < N_RES; j++) begin
                lambda_q[j] <= N_IN'(1) << j;
            end
            cube_q    <= '0;
            pol_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            lambda_q  <= lambda_d;
            cube_q    <= cube_d;
            pol_q     <= pol_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Valid bits and stage data registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            z1_q <= '0;
            m2_q <= '0;
            y_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            z1_q <= z1_d;
            m2_q <= m2_d;
            y_q  <= y_d;
        end
    end

endmodule

// File: tb/tb_pla_res_eval_pipe.sv
// Self-checking bench for pla_res_eval_pipe. A behavioural model of the
// configured function predicts each result when a vector is accepted;
// the prediction is queued and compared when the DUT hands out a result.
module tb_pla_res_eval_pipe;
    import pla_res_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_sel = '0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [CW-1:0]    cfg_data = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N_IN-1:0]  in_x = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N_OUT-1:0] out_y;

    always #5 clk = ~clk;

    pla_res_eval_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    logic exp_q[$];

    // Shadow of the configuration the bench intends the DUT to hold.
    logic [N_IN-1:0]  m_lam   [N_RES];
    logic [N_RES-1:0] m_care  [N_TERMS];
    logic [N_RES-1:0] m_val   [N_TERMS];
    logic             m_omask [N_TERMS];
    logic             m_pol;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic model(input logic [N_IN-1:0] x);
        logic [N_RES-1:0] zz;
        logic hit;
        zz  = '0;
        hit = 1'b0;
        for (int j = 0; j < N_RES; j++) zz[j] = ^(x & m_lam[j]);
        for (int t = 0; t < N_TERMS; t++)
            if (m_omask[t] && ((zz & m_care[t]) == (m_val[t] & m_care[t]))) hit = 1'b1;
        return hit ^ m_pol;
    endfunction

    task automatic mirror_defaults();
        for (int j = 0; j < N_RES; j++) m_lam[j] = N_IN'(1) << j;
        for (int t = 0; t < N_TERMS; t++) begin
            m_care[t]  = '0;
            m_val[t]   = '0;
            m_omask[t] = 1'b0;
        end
        m_pol = 1'b0;
    endtask

    // Scoreboard: sample handshakes on the falling edge, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
                else check("y", 32'(out_y), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_x));
        end
    end

    // All drivers start at posedge+1 and return at posedge+1.
    task automatic send(input logic [N_IN-1:0] x);
        int budget;
        budget   = 60;
        in_valid = 1'b1;
        in_x     = x;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [AW-1:0] addr,
                             input logic [CW-1:0] data, input logic exp_err);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        check("cfg_err", 32'(cfg_err), 32'(exp_err));
        if (!exp_err) begin
            case (sel)
                2'd0: m_lam[addr[2:0]] = data[N_IN-1:0];
                2'd1: begin
                    m_care[addr]  = data[16:9];
                    m_val[addr]   = data[8:1];
                    m_omask[addr] = data[0];
                end
                2'd2: m_pol = data[0];
                default: ;
            endcase
        end
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        @(negedge clk);
        while ((exp_q.size() != 0 || !cfg_ready) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        mirror_defaults();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_before;
        mirror_defaults();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y",     32'(out_y),     32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_cfg_err",   32'(cfg_err),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // 1: single cube on identity lambda, with latency check
        cfg_write(2'(SEL_CUBE), 4'd0, {8'h03, 8'h01, 1'b1}, 1'b0);
        send(14'h0001);
        check("lat_e0", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_e1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_e2", 32'(out_valid), 32'd1);
        check("lat_y",  32'(out_y),     32'd1);
        send(14'h0003);
        drain();

        // 2: XOR projection through a two-input lambda row
        cfg_write(2'(SEL_LAMBDA), 4'd0, 17'h02001, 1'b0);
        cfg_write(2'(SEL_CUBE), 4'd0, {8'h01, 8'h01, 1'b1}, 1'b0);
        send(14'h2000);
        send(14'h2001);
        drain();

        // 3: empty cover with inverted polarity is constant 1
        do_reset();
        cfg_write(2'(SEL_POL), 4'd0, 17'h00001, 1'b0);
        send(14'h0000);
        send(14'h3FFF);
        for (int i = 0; i < 8; i++) send(14'($urandom_range(0, 16383)));
        drain();

        // 4: backpressure with alternating results (y = !x[0])
        cfg_write(2'(SEL_CUBE), 4'd0, {8'h01, 8'h01, 1'b1}, 1'b0);
        out_ready = 1'b0;
        n_before  = n_out;
        send(14'h0001);
        send(14'h0000);
        send(14'h0001);
        check("stall_in_ready",  32'(in_ready),  32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        fork
            send(14'h0000);
        join_none
        repeat (5) @(posedge clk);
        #1;
        check("hold_valid",    32'(out_valid),    32'd1);
        check("hold_y",        32'(out_y),        32'(exp_q[0]));
        check("hold_in_ready", 32'(in_ready),     32'd0);
        check("hold_queue",    32'(exp_q.size()), 32'd3);
        out_ready = 1'b1;
        wait fork;
        drain();
        check("stream_count", 32'(n_out - n_before), 32'd4);

        // 5: dropped writes
        cfg_write(2'(SEL_CUBE), 4'd0, {8'h0F, 8'h05, 1'b1}, 1'b0);
        send(14'h0000);
        cfg_write(2'(SEL_CUBE), 4'd0, {8'h00, 8'h00, 1'b1}, 1'b1);
        @(posedge clk); #1;
        check("err_pulse_end", 32'(cfg_err), 32'd0);
        drain();
        send(14'h0000);
        send(14'h0005);
        drain();
        cfg_write(2'd3, 4'd0, 17'h1FFFF, 1'b1);
        cfg_write(2'(SEL_LAMBDA), 4'd8, 17'h00000, 1'b1);
        send(14'h0000);
        drain();

        // 6: reset mid-stream restores defaults
        cfg_write(2'(SEL_LAMBDA), 4'd0, 17'h00100, 1'b0);
        send(14'h0011);
        send(14'h0022);
        send(14'h0033);
        rst = 1'b1;
        exp_q.delete();
        mirror_defaults();
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_cfg_ready", 32'(cfg_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        send(14'h00FF);
        drain();
        cfg_write(2'(SEL_CUBE), 4'd0, {8'hFF, 8'hFF, 1'b1}, 1'b0);
        send(14'h00FF);
        send(14'h3F00);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
